// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// The result is a one-hot {greater, less, equal} triple, all-zero after reset.
package comparator_pkg;

    typedef struct packed {
        logic greater;
        logic less;
        logic equal;
    } cmp_result_t;

    localparam cmp_result_t CMP_GT    = cmp_result_t'(3'b100);
    localparam cmp_result_t CMP_LT    = cmp_result_t'(3'b010);
    localparam cmp_result_t CMP_EQ    = cmp_result_t'(3'b001);
    localparam cmp_result_t CMP_RESET = cmp_result_t'(3'b000);

endpackage : comparator_pkg

// File: rtl/comparator_4bit_sync_if.sv
// Operand/result bundle for comparator_4bit_sync.
// When COMPARATOR_SIGNED_EN is defined the bundle also carries signed_mode.
interface comparator_4bit_sync_if #(
    parameter int WIDTH = 4
);

    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
`ifdef COMPARATOR_SIGNED_EN
    logic             signed_mode;
`endif
    logic             out_valid;
    logic             greater;
    logic             less;
    logic             equal;

    // Producer of operands, consumer of flags.
    modport master (
`ifdef COMPARATOR_SIGNED_EN
        output signed_mode,
`endif
        output in_valid, A, B,
        input  out_valid, greater, less, equal
    );

    // The comparator itself.
    modport slave (
`ifdef COMPARATOR_SIGNED_EN
        input  signed_mode,
`endif
        input  in_valid, A, B,
        output out_valid, greater, less, equal
    );

endinterface : comparator_4bit_sync_if

// File: rtl/comparator_bit_slice.sv
// One-bit cascade cell of the magnitude comparator. Slices are chained from
// MSB to LSB; once a higher slice has decided greater/less, lower slices only
// pass that decision through.
module comparator_bit_slice (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_i,
    input  logic lt_i,
    input  logic eq_i,
    output logic gt_o,
    output logic lt_o,
    output logic eq_o
);

    // This bit decides only while every more significant bit was equal.
    always_comb begin
        gt_o = gt_i | (eq_i &  a_bit & ~b_bit);
        lt_o = lt_i | (eq_i & ~a_bit &  b_bit);
        eq_o = eq_i & ~(a_bit ^ b_bit);
    end

endmodule : comparator_bit_slice

// File: rtl/comparator_4bit_sync.sv
// Registered magnitude comparator: one-hot greater/less/equal of A versus B,
// one cycle latency, one compare per cycle, synchronous active-high reset.
// Optional feature: COMPARATOR_SIGNED_EN adds signed_mode (two's-complement).
module comparator_4bit_sync
    import comparator_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    comparator_4bit_sync_if.slave  bus
);

    // Operand bits as seen by the slice chain.
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;

    // Cascade wires; index WIDTH is the seed entering the MSB slice.
    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] lt_c;
    logic [WIDTH:0] eq_c;

    cmp_result_t cmp_now;
    cmp_result_t result_d;
    cmp_result_t result_q;
    logic        out_valid_d;
    logic        out_valid_q;

`ifdef COMPARATOR_SIGNED_EN
    // Signed compare: swapping the sign bits in the MSB slice exchanges
    // greater/less exactly when the signs differ; lower bits stay unsigned.
    always_comb begin
        a_eff = bus.A;
        b_eff = bus.B;
        if (bus.signed_mode) begin
            a_eff[WIDTH-1] = bus.B[WIDTH-1];
            b_eff[WIDTH-1] = bus.A[WIDTH-1];
        end
    end
`else
    assign a_eff = bus.A;
    assign b_eff = bus.B;
`endif

    assign gt_c[WIDTH] = 1'b0;
    assign lt_c[WIDTH] = 1'b0;
    assign eq_c[WIDTH] = 1'b1;

    for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_slice
        comparator_bit_slice u_slice (
            .a_bit (a_eff[i]),
            .b_bit (b_eff[i]),
            .gt_i  (gt_c[i+1]),
            .lt_i  (lt_c[i+1]),
            .eq_i  (eq_c[i+1]),
            .gt_o  (gt_c[i]),
            .lt_o  (lt_c[i]),
            .eq_o  (eq_c[i])
        );
    end

    assign cmp_now = '{greater: gt_c[0], less: lt_c[0], equal: eq_c[0]};

    // Capture a new result on valid operands; otherwise hold the flags.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        out_valid_d = 1'b0;
        result_d    = result_q;
        if (bus.in_valid) begin
            out_valid_d = 1'b1;
            result_d    = cmp_now;
        end
    end

    // Output registers with synchronous reset taking priority over in_valid.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value regardless of statement order.
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= CMP_RESET;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.greater   = result_q.greater;
    assign bus.less      = result_q.less;
    assign bus.equal     = result_q.equal;

endmodule : comparator_4bit_sync

// File: tb/tb_comparator_4bit_sync.sv
// Self-checking bench for comparator_4bit_sync. Expected flags come from an
// integer-arithmetic reference model of the compare, with hold-on-invalid and
// reset behaviour tracked alongside. Define COMPARATOR_SIGNED_EN to cover the
// signed_mode port.
module tb_comparator_4bit_sync;
    import comparator_pkg::*;

    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Reference state: what the outputs must show after the latest edge.
    logic        exp_valid = 1'b0;
    cmp_result_t exp_res   = CMP_RESET;

    comparator_4bit_sync_if #(.WIDTH(WIDTH)) bus ();

    comparator_4bit_sync #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Numeric value of an operand, optionally read as two's complement.
    function automatic int as_value(input logic [WIDTH-1:0] v, input bit sgn);
        if (sgn && v[WIDTH-1]) return int'(v) - (2 ** WIDTH);
        return int'(v);
    endfunction

    function automatic cmp_result_t ref_rel(input int a, input int b);
        if (a > b) return CMP_GT;
        if (a < b) return CMP_LT;
        return CMP_EQ;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the reference model, and compare after the edge.
    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit sm, input string tag);
        bit sgn;
        rst          = r;
        bus.in_valid = v;
        bus.A        = v ? a : 'x;
        bus.B        = v ? b : 'x;
`ifdef COMPARATOR_SIGNED_EN
        bus.signed_mode = sm;
        sgn = sm;
`else
        sgn = 1'b0;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            exp_valid = 1'b0;
            exp_res   = CMP_RESET;
        end else if (v) begin
            exp_valid = 1'b1;
            exp_res   = ref_rel(as_value(a, sgn), as_value(b, sgn));
        end else begin
            exp_valid = 1'b0;
        end
        check(tag, {bus.out_valid, bus.greater, bus.less, bus.equal}, {exp_valid, exp_res});
    endtask

    initial begin
        logic [WIDTH-1:0] pa [$];
        logic [WIDTH-1:0] pb [$];

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
`ifdef COMPARATOR_SIGNED_EN
        bus.signed_mode = 1'b0;
`endif

        // Reset state.
        step(1, 0, 0, 0, 0, "reset0");
        step(1, 0, 0, 0, 0, "reset1");

        // Equal, greater, less directed pairs, applied back to back.
        pa = '{5, 15, 0, 10, 8, 6, 15, 3, 0, 5};
        pb = '{5, 15, 0, 10, 7, 3, 0, 6, 15, 10};
        foreach (pa[i])
            step(0, 1, pa[i], pb[i], 0, $sformatf("directed_%0d_%0d", pa[i], pb[i]));

        // GT, LT, EQ every cycle, then an invalid gap that must hold the flags.
        step(0, 1, 8, 7, 0, "b2b_gt");
        step(0, 1, 3, 6, 0, "b2b_lt");
        step(0, 1, 5, 5, 0, "b2b_eq");
        step(0, 0, 0, 0, 0, "gap0");
        step(0, 0, 0, 0, 0, "gap1");
        step(0, 1, 9, 2, 0, "after_gap");

        // Reset beats in_valid on the same edge; next pair is reported normally.
        step(1, 1, 15, 0, 0, "rst_vs_valid");
        step(0, 1, 3, 9, 0, "post_rst");

`ifdef COMPARATOR_SIGNED_EN
        step(0, 1, 8, 7, 1, "signed_8_7");
        step(0, 1, 15, 0, 1, "signed_15_0");
        step(0, 1, 8, 7, 0, "unsigned_8_7");
        step(0, 1, 15, 0, 0, "unsigned_15_0");
        step(0, 1, 7, 8, 1, "signed_7_8");
        step(0, 1, 9, 14, 1, "signed_9_14");
`endif

        // Exhaustive unsigned sweep with a one-hot check on every result.
        for (int a = 0; a < 2 ** WIDTH; a++) begin
            for (int b = 0; b < 2 ** WIDTH; b++) begin
                step(0, 1, WIDTH'(a), WIDTH'(b), 0, $sformatf("sweep_%0d_%0d", a, b));
                check("sweep_onehot", 4'($countones({bus.greater, bus.less, bus.equal})), 4'd1);
            end
        end

        // Random traffic: sporadic reset, invalid gaps, mixed modes.
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0,
                 WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rand_%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_comparator_4bit_sync

// File: doc/comparator_4bit_sync.md
# comparator_4bit_sync

Registered magnitude comparator for two 4-bit operands. Each cycle it produces one-hot `greater` / `less` / `equal` flags describing A relative to B. It is a small leaf datapath block used wherever control logic needs a clocked compare result. Outputs are registered for clean timing at the consumer.

## Interface
- `WIDTH`, default 4: operand width in bits; the block must be correct for any value ≥ 1.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  A and B are valid this cycle.
- `A`  input  WIDTH  first operand.
- `B`  input  WIDTH  second operand.
- `signed_mode`  input  1  present only when `COMPARATOR_SIGNED_EN` is defined; 1 selects two's-complement compare.
- `out_valid`  output  1  flags reflect a captured operand pair.
- `greater`  output  1  A > B.
- `less`  output  1  A < B.
- `equal`  output  1  A == B.

## Operation
- The compare is combinational on A and B; the result is captured into output registers.
- When `in_valid`=1: exactly one of `greater`/`less`/`equal` is registered as 1.
- When `in_valid`=0: the flags hold their previous values, and `out_valid` is registered as 0.
- Default compare is unsigned magnitude: the MSB is most significant and there is no wrap-around.
- `equal` is the bitwise equality of all WIDTH bits.
- `greater` and `less` are decided by the most significant differing bit.
- There is no backpressure and no stall input. A new pair can be accepted every cycle.
- X/Z on A or B while `in_valid`=0 must not affect the outputs.

## Timing
- Latency is 1 cycle. Operands sampled at rising edge N appear on the outputs after edge N, valid during cycle N+1.
- Throughput is one compare per cycle.
- Reset values: `out_valid`=0, `greater`=0, `less`=0, `equal`=0.
- Reset has priority over `in_valid` on the same edge. An operand pair presented during reset is discarded.
- Reset asserted mid-stream clears all outputs on the next edge; operation resumes on the first edge after `rst` deasserts.
- `signed_mode` is sampled on the same edge as the operands. Changing it between pairs affects only that pair.

## Configuration
- Macro: `COMPARATOR_SIGNED_EN`.
- Defined:
  - the `signed_mode` port exists;
  - with `signed_mode`=1, A and B are compared as two's-complement values (e.g. 4'b1000 = -8 < 4'b0111 = 7);
  - with `signed_mode`=0, the compare is unsigned.
- Undefined:
  - the port is absent;
  - the compare is always unsigned;
  - no signed logic is synthesized.

## Structure
- Shared package `comparator_pkg`:
  - `cmp_result_t`, a 3-bit packed struct {greater, less, equal};
  - localparam one-hot constants `CMP_GT`, `CMP_LT`, `CMP_EQ`;
  - localparam `CMP_RESET` = all zeros.
- Sub-module `comparator_bit_slice`: 1-bit cascade cell.
  - Inputs: a_bit, b_bit, and the upstream gt/lt/eq.
  - Outputs: gt/lt/eq.
  - The top instantiates WIDTH slices from MSB to LSB via generate.
- Signed mode swaps the treatment of the MSB slice, i.e. `greater`/`less` are exchanged when the sign bits differ.

## Test plan
- Reset, then equal pairs 5/5, 15/15, 0/0, 10/10 with `in_valid`=1 -> `equal`=1, `greater`=`less`=0 and `out_valid`=1, one cycle after each pair.
- Unsigned greater: 8/7, 6/3, 15/0 -> `greater`=1 only. Unsigned less: 3/6, 0/15, 5/10 -> `less`=1 only.
- Back-to-back pairs every cycle (8/7, 3/6, 5/5) -> outputs follow with 1-cycle latency, pattern GT, LT, EQ. `in_valid`=0 gap -> `out_valid`=0 and flags hold.
- `rst`=1 asserted together with `in_valid`=1 and A=15, B=0 -> next cycle all outputs 0. First pair after reset release is reported correctly.
- With `COMPARATOR_SIGNED_EN`:
  - `signed_mode`=1, 8/7 -> `less`=1;
  - `signed_mode`=1, 15/0 -> `less`=1 (-1 < 0);
  - `signed_mode`=0, same pairs -> `greater`=1.
- Exhaustive sweep of all 256 A/B pairs, unsigned -> exactly one flag set and matching the reference relation.
